// File: rtl/arb_mux_pkg.sv
// Shared defaults and helpers for the arbitrated multiplexer slice.
package arb_mux_pkg;

  localparam int ARB_MUX_DEF_WIDTH = 32;
  localparam int ARB_MUX_DEF_N     = 4;

  // Grant index width; a single channel still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: first valid channel at or above ptr, wrapping to 0.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int N    = ARB_MUX_DEF_N,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] idx
);

  logic found;

  // Two passes instead of modular indexing: upper segment [ptr, N-1], then wrapped segment [0, ptr-1].
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && valid[j] && (j >= 32'(ptr))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDXW'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && valid[j] && (j < 32'(ptr))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated mux with registered output and valid/ready handshakes.
// Define ARB_MUX_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH = ARB_MUX_DEF_WIDTH,
  parameter  int N     = ARB_MUX_DEF_N,
  localparam int IDXW  = idx_width(N)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N*WIDTH-1:0] ARB_IN,
  input  logic [N-1:0]       ARB_InValid,
  output logic [N-1:0]       ARB_InReady,
  output logic [WIDTH-1:0]   ARB_OUT,
  output logic               ARB_OutValid,
  input  logic               ARB_OutReady,
  output logic [IDXW-1:0]    ARB_GrantIdx
);

  logic             ld;
  logic             in_xfer;
  logic [N-1:0]     grant;
  logic [IDXW-1:0]  win_idx;
  logic [IDXW-1:0]  ptr;
  logic [WIDTH-1:0] win_data;

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .valid (ARB_InValid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  assign ld          = ~ARB_OutValid | ARB_OutReady;
  assign ARB_InReady = grant & {N{ld}};
  assign in_xfer     = |ARB_InReady;

  // Grant is one-hot, so an AND-OR mux selects the winner's data.
  always_comb begin
    win_data = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (grant[j]) win_data = win_data | ARB_IN[j*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ARB_OUT      <= '0;
      ARB_GrantIdx <= '0;
      ARB_OutValid <= 1'b0;
    end else if (in_xfer) begin
      ARB_OUT      <= win_data;
      ARB_GrantIdx <= win_idx;
      ARB_OutValid <= 1'b1;
    end else if (ARB_OutReady) begin
      ARB_OutValid <= 1'b0;
    end
  end

`ifdef ARB_MUX_RR_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= '0;
    end else if (in_xfer) begin
      ptr <= (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);
    end
  end
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: N=4/WIDTH=32 main instance plus an N=3/WIDTH=8 wrap instance.
module tb_arb_mux;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
  } item_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic [3:0]   iv, ir;
  logic [31:0]  dout;
  logic         ov, ordy;
  logic [1:0]   gidx;

  logic [23:0]  din3;
  logic [2:0]   iv3, ir3;
  logic [7:0]   dout3;
  logic         ov3, ordy3;
  logic [1:0]   gidx3;

  int          checks = 0;
  int          errors = 0;
  int unsigned tag    = 0;
  item_t       sbq[$];

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(32), .N(4)) u_dut (
    .CLK(clk), .RST(rst), .ARB_IN(din), .ARB_InValid(iv), .ARB_InReady(ir),
    .ARB_OUT(dout), .ARB_OutValid(ov), .ARB_OutReady(ordy), .ARB_GrantIdx(gidx)
  );

  arb_mux #(.WIDTH(8), .N(3)) u_dut3 (
    .CLK(clk), .RST(rst), .ARB_IN(din3), .ARB_InValid(iv3), .ARB_InReady(ir3),
    .ARB_OUT(dout3), .ARB_OutValid(ov3), .ARB_OutReady(ordy3), .ARB_GrantIdx(gidx3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int unsigned ch, input int unsigned t);
    return (32'(t) << 16) | 32'h0000_A000 | 32'(ch);
  endfunction

  // One cycle on the N=4 instance; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic [3:0] v, input logic rdy, input logic [1:0] exp_idx,
                      input logic exp_go, input string name);
    tag++;
    iv   = v;
    ordy = rdy;
    for (int i = 0; i < 4; i++) din[i*32 +: 32] = pat(i, tag);
    #1;
    check({name, "_inready"}, 32'(ir), exp_go ? 32'(4'b0001 << exp_idx) : 32'h0);
    if (exp_go) sbq.push_back('{data: pat(exp_idx, tag), idx: exp_idx});
    @(posedge clk); #1;
  endtask

  task automatic step3(input logic [2:0] v, input logic [1:0] exp_idx, input string name);
    iv3 = v;
    #1;
    check({name, "_inready"}, 32'(ir3), 32'(3'b001 << exp_idx));
    @(posedge clk); #1;
    check({name, "_grant"}, 32'(gidx3), 32'(exp_idx));
    check({name, "_data"}, 32'(dout3), 32'(8'hA0 + 8'h11 * 8'(exp_idx)));
  endtask

  always @(negedge clk) begin : monitor
    item_t e;
    if (!rst && ov && ordy) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=%h required=no_output", dout);
      end else begin
        e = sbq.pop_front();
        check("sb_data", dout, e.data);
        check("sb_idx", 32'(gidx), 32'(e.idx));
      end
    end
    if (!rst && ov3) check("n3_idx_range", 32'(gidx3 < 2'd3), 32'd1);
  end

`ifdef ARB_MUX_RR_EN
  logic [1:0] seq[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  localparam logic [1:0] REL1 = 2'd1;
  localparam logic [1:0] N3_A = 2'd1;
  localparam logic [1:0] N3_B = 2'd2;
`else
  logic [1:0] seq[5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [1:0] REL1 = 2'd0;
  localparam logic [1:0] N3_A = 2'd0;
  localparam logic [1:0] N3_B = 2'd1;
`endif

  logic [31:0] held;

  initial begin
    rst = 1'b1; iv = '0; ordy = 1'b0; din = '0;
    iv3 = '0; ordy3 = 1'b1; din3 = {8'hC2, 8'hB1, 8'hA0};
    #2;
    check("rst_valid", 32'(ov), 32'd0);
    check("rst_out", dout, 32'd0);
    check("rst_idx", 32'(gidx), 32'd0);
    check("rst_inready", 32'(ir), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single requester on channel 2
    iv = 4'b0100; ordy = 1'b1;
    din = {32'h3333_3333, 32'hA5A5_A5A5, 32'h1111_1111, 32'h0000_0000};
    #1;
    check("single_inready", 32'(ir), 32'h4);
    sbq.push_back('{data: 32'hA5A5_A5A5, idx: 2'd2});
    @(posedge clk); #1;
    check("single_out", dout, 32'hA5A5_A5A5);
    check("single_idx", 32'(gidx), 32'd2);
    check("single_valid", 32'(ov), 32'd1);
    step(4'b0000, 1'b1, 2'd0, 1'b0, "idle");

    // Load an item, stall it, then reset asynchronously mid-cycle
    step(4'b0001, 1'b0, 2'd0, 1'b1, "preload");
    iv = '0; ordy = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(ov), 32'd0);
    check("async_rst_out", dout, 32'd0);
    check("async_rst_idx", 32'(gidx), 32'd0);
    sbq.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) step(4'b1111, 1'b1, seq[k], 1'b1, "arb");

    // Backpressure: three stalled cycles, item and pointer must hold
    held = sbq[$].data;
    for (int k = 0; k < 3; k++) begin
      step(4'b0011, 1'b0, 2'd0, 1'b0, "stall");
      check("stall_out", dout, held);
      check("stall_valid", 32'(ov), 32'd1);
    end
    step(4'b0011, 1'b1, REL1, 1'b1, "release");
    step(4'b0011, 1'b1, 2'd0, 1'b1, "release2");
    step(4'b0000, 1'b1, 2'd0, 1'b0, "drain");
    check("drain_valid", 32'(ov), 32'd0);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    // N=3 wrap behaviour
    step3(3'b100, 2'd2, "n3_ch2");
    step3(3'b101, 2'd0, "n3_wrap");
    step3(3'b111, N3_A, "n3_all");
    step3(3'b110, N3_B, "n3_hi");
    iv3 = '0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel arbitrated multiplexer with a registered output and valid/ready handshakes on every channel. It is the successor to the plain 2x1 select mux. Each cycle it picks one requesting input, either fixed-priority or round-robin, and registers the winner's data together with its channel index. It sits between multiple producers (e.g. fetch, load/store, debug ports) and a single shared consumer such as the memory interface.

## Interface
- WIDTH, 32, data width per channel (>=1)
- N, 4, number of input channels (>=1)
- IDXW, derived localparam = max(1, clog2(N)), grant index width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- ARB_IN  in  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- ARB_InValid  in  N  per-channel request
- ARB_InReady  out  N  per-channel accept, at most one bit set
- ARB_OUT  out  WIDTH  registered winning data
- ARB_OutValid  out  1  ARB_OUT holds an item
- ARB_OutReady  in  1  consumer accepts ARB_OUT
- ARB_GrantIdx  out  IDXW  channel index that produced ARB_OUT

## Operation
- Transfers: input i moves when ARB_InValid[i] & ARB_InReady[i]. Output moves when ARB_OutValid & ARB_OutReady.
- Load enable: LD = ~ARB_OutValid | ARB_OutReady. ARB_InReady = onehot(winner) & {N{LD}}, and is all-zero when no channel is valid.
- Winner is computed combinationally from ARB_InValid and the priority pointer PTR (IDXW bits). Search starts at channel PTR and goes upward with wrap-around. The first valid channel wins.
- On an input transfer: ARB_OUT <= winner data, ARB_GrantIdx <= winner, ARB_OutValid <= 1.
- On an output transfer with no input transfer: ARB_OutValid <= 0. ARB_OUT and ARB_GrantIdx hold their last values.
- Output transfer and input transfer in the same cycle: the new item replaces the old one, ARB_OutValid stays 1, and there is no bubble.
- Stall (ARB_OutValid=1, ARB_OutReady=0): ARB_OUT, ARB_GrantIdx and ARB_OutValid hold. ARB_InReady = 0. PTR holds.
- ARB_InValid may drop without a transfer. The arbiter re-evaluates every cycle, so there is no grant lock.
- Reset values: ARB_OUT=0, ARB_GrantIdx=0, ARB_OutValid=0, PTR=0. ARB_InReady follows LD and is therefore live in the first cycle after reset deassertion.
- Reset mid-operation: any buffered item is dropped and the pointer returns to 0. Producers must re-present their data.
- N=1: the block is a 1-deep register slice, PTR is constant 0, and ARB_GrantIdx is always 0.
- N not a power of 2: PTR and the winner wrap from N-1 to 0. Indices >= N are never produced.

## Timing
- Latency: 1 cycle from input transfer to ARB_OutValid/ARB_OUT.
- Throughput: 1 item per cycle while ARB_OutReady=1.
- Combinational paths: ARB_OutReady -> ARB_InReady, and ARB_InValid -> ARB_InReady. There is no combinational path from ARB_IN to any output.

## Configuration
- ARB_MUX_RR_EN defined: round-robin. After each input transfer from channel g, PTR <= (g+1) mod N.
- ARB_MUX_RR_EN undefined: fixed priority. PTR is tied to 0, so the lowest valid index always wins and the pointer register is removed.

## Structure
- Package arb_mux_pkg holds ARB_MUX_DEF_WIDTH=32, ARB_MUX_DEF_N=4, and a constant function idx_width(n) returning max(1, clog2(n)).
- Sub-module rr_pick is purely combinational: inputs are the valid vector and PTR, outputs are the one-hot grant and the winner index. It is instanced once.
- The top level holds the output register, the LD logic and the PTR register.

## Test plan
- Reset: assert RST asynchronously mid-stream with ARB_OutValid=1. Required: ARB_OutValid=0, ARB_OUT=0 and ARB_GrantIdx=0 immediately, without waiting for a clock edge.
- Single channel: N=4, only ARB_InValid=4'b0100 with data 0xA5A5A5A5. Required: ARB_InReady=4'b0100, then ARB_OUT=0xA5A5A5A5 and ARB_GrantIdx=2 one cycle later.
- Round-robin (RR_EN defined): InValid=4'b1111 held, OutReady=1. Required: grant sequence 0,1,2,3,0 on consecutive cycles.
- Fixed priority (RR_EN undefined): same stimulus. Required: grant is 0 every cycle and channels 1-3 are starved.
- Backpressure: OutReady=0 for 3 cycles with InValid=4'b0011. Required: ARB_OUT stable, ARB_InReady=0 and PTR unchanged. On release, pass-through continues with no lost or duplicated item.
- Wrap with N=3 and RR_EN: grant 2 then InValid=3'b101. Required: next grant 0 and ARB_GrantIdx never reaches 3.
